// File: rtl/cache_pkg.sv
// Shared types and default geometry for the cache/memory arbiter.
// The line offset width is derived from the default beat count and beat width.
package cache_pkg;

    localparam int ARB_ADDR_W = 64;
    localparam int ARB_DATA_W = 64;
    localparam int ARB_BEATS  = 8;
    localparam int LINE_OFF_W = $clog2(ARB_BEATS * ARB_DATA_W / 8);

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ADDR,
        ARB_RDATA,
        ARB_WDATA
    } arb_state_t;

    typedef enum logic {
        OWN_IC,
        OWN_DC
    } arb_owner_t;

endpackage

// File: rtl/cache_mem_arbiter.sv
// Shares the external memory port between icache refills and dcache refills/writebacks.
// One burst at a time: grant, address phase, then read or write beats routed to the owner.
module cache_mem_arbiter
    import cache_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W,
    parameter int BEATS  = ARB_BEATS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_gnt,
    output logic              ic_rvalid,
    output logic              ic_rlast,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    output logic              dc_gnt,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              dc_wready,
    output logic              dc_rvalid,
    output logic              dc_rlast,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_we,
    output logic              mem_wvalid,
    input  logic              mem_wready,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int OFF_W = $clog2(BEATS * DATA_W / 8);
    localparam int CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    arb_state_t        state_reg, state_next;
    arb_owner_t        owner_reg, owner_next;
    arb_owner_t        rr_last_reg, rr_last_next;
    logic              we_reg, we_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              pick_dc;
    logic              last_beat;

    // dcache wins when alone, or on a tie when icache had the previous grant.
    assign pick_dc   = dc_req && (!ic_req || (rr_last_reg == OWN_IC));
    assign last_beat = (cnt_reg == LAST_BEAT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ARB_IDLE;
            owner_reg   <= OWN_IC;
            rr_last_reg <= OWN_IC;
            we_reg      <= 1'b0;
            addr_reg    <= '0;
            cnt_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            owner_reg   <= owner_next;
            rr_last_reg <= rr_last_next;
            we_reg      <= we_next;
            addr_reg    <= addr_next;
            cnt_reg     <= cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        owner_next   = owner_reg;
        rr_last_next = rr_last_reg;
        we_next      = we_reg;
        addr_next    = addr_reg;
        cnt_next     = cnt_reg;
        case (state_reg)
            ARB_IDLE: begin
                if (ic_req || dc_req) begin
                    state_next = ARB_ADDR;
                    if (pick_dc) begin
                        owner_next   = OWN_DC;
                        rr_last_next = OWN_DC;
                        we_next      = dc_we;
                        addr_next    = {dc_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    end else begin
                        owner_next   = OWN_IC;
                        rr_last_next = OWN_IC;
                        we_next      = 1'b0;
                        addr_next    = {ic_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    end
                end
            end
            ARB_ADDR: begin
                if (mem_req_ready) begin
                    state_next = we_reg ? ARB_WDATA : ARB_RDATA;
                    cnt_next   = '0;
                end
            end
            ARB_RDATA: begin
                if (mem_rvalid) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                    if (last_beat) begin
                        state_next = ARB_IDLE;
                    end
                end
            end
            ARB_WDATA: begin
                if (mem_wready) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                    if (last_beat) begin
                        state_next = ARB_IDLE;
                    end
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    // Outputs are forced low while reset is held, including the combinational grant.
    always_comb begin
        ic_gnt        = 1'b0;
        ic_rvalid     = 1'b0;
        ic_rlast      = 1'b0;
        dc_gnt        = 1'b0;
        dc_wready     = 1'b0;
        dc_rvalid     = 1'b0;
        dc_rlast      = 1'b0;
        rdata         = '0;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        mem_req_we    = 1'b0;
        mem_wvalid    = 1'b0;
        mem_wdata     = '0;
        if (reset) begin
            case (state_reg)
                ARB_IDLE: begin
                    dc_gnt = pick_dc;
                    ic_gnt = ic_req && !pick_dc;
                end
                ARB_ADDR: begin
                    mem_req_valid = 1'b1;
                    mem_req_addr  = addr_reg;
                    mem_req_we    = we_reg;
                end
                ARB_RDATA: begin
                    if (mem_rvalid) begin
                        rdata = mem_rdata;
                        if (owner_reg == OWN_DC) begin
                            dc_rvalid = 1'b1;
                            dc_rlast  = last_beat;
                        end else begin
                            ic_rvalid = 1'b1;
                            ic_rlast  = last_beat;
                        end
                    end
                end
                ARB_WDATA: begin
                    mem_wvalid = 1'b1;
                    mem_wdata  = dc_wdata;
                    dc_wready  = mem_wready;
                end
                default: ;
            endcase
        end
    end

endmodule
